reg_bus_interconnect: RTL and testbench
=======================================

Name: reg_bus_interconnect

Overview:
- Parametrised replacement for the hand-instanced OR-reduction of slave ack/data_out/data_out_valid on the 4-bit register bus.
- Sits between address_decoder (master side) and N register slaves: clock handler, UART, channel processor, color processor and later additions.
- Adds what plain OR-ing lacks: registered single-cycle responses, detection of multiple simultaneous acks (collision), a no-ack timeout, and a saturating error counter.

Parameters:
- N_SLAVES, 4, number of slave ports (1..16).
- ADDR_W, 4, register address width.
- DATA_W, 4, register data width.
- TIMEOUT, 15, cycles waited for an ack before aborting (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- m_valid  in  1  request from decoder; a level, held until m_ack is seen.
- m_address  in  ADDR_W  request address.
- m_data  in  DATA_W  request data.
- m_ack  out  1  one-cycle completion pulse to the decoder.
- m_data_out  out  DATA_W  read data; held until the next completion.
- m_data_out_valid  out  1  one-cycle pulse, coincident with m_ack, when read data is returned.
- s_valid  out  1  request broadcast to all slaves.
- s_address  out  ADDR_W  latched address, broadcast.
- s_data  out  DATA_W  latched data, broadcast.
- s_ack  in  N_SLAVES  per-slave ack; bit i belongs to slave i.
- s_data_out  in  N_SLAVES*DATA_W  slave i occupies bits [i*DATA_W +: DATA_W].
- s_data_out_valid  in  N_SLAVES  per-slave read-data valid.
- err_timeout  out  1  one-cycle pulse, coincident with m_ack, on a timeout abort.
- err_collision  out  1  one-cycle pulse, coincident with m_ack, when more than one ack is seen.
- err_count  out  8  saturating count of timeouts plus collisions.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- FSM state IDLE:
  - On m_valid=1, latch m_address and m_data into s_address/s_data.
  - Go to WAIT.
  - s_valid rises on the cycle after m_valid is first sampled high.
- FSM state WAIT:
  - s_valid=1; counter increments every cycle.
  - Completion cycle: the first cycle with s_ack != 0.
  - Winner: the lowest-index set bit of s_ack.
  - If s_data_out_valid[winner]=1 in that cycle, capture that slave's data slice into m_data_out.
  - If more than one s_ack bit is set, flag a collision. The winner's data is still used.
  - Go to RESP.
  - If counter reaches TIMEOUT with s_ack==0: go to RESP with the timeout flag set and m_data_out forced to 0.
- FSM state RESP:
  - Lasts exactly one cycle; s_valid=0.
  - m_ack=1.
  - m_data_out_valid=1 only if data was captured.
  - err_timeout / err_collision = 1 per the flags set in WAIT.
  - err_count increments by 1 if either flag is set; saturates at 255.
  - Go to DRAIN.
- FSM state DRAIN:
  - Wait for m_valid==0, then go to IDLE. This prevents re-issuing a held request.
  - Slave acks arriving in DRAIN or IDLE are ignored and are not counted.
- Latency:
  - Ack seen in WAIT cycle k (k=1 is the first WAIT cycle) → m_ack in cycle k+1.
  - Best case: m_valid sampled at cycle 0 → m_ack at cycle 2.
- Timeout case: m_ack appears TIMEOUT+1 cycles after entering WAIT.
- Late or only-ack slaves: a slave that acks without data_out_valid completes a write; m_data_out keeps its previous value.
- Reset mid-operation:
  - Asynchronous return to IDLE; s_valid drops immediately; err_count is cleared.
  - No m_ack is generated for the aborted request.
- N_SLAVES=1: collision is impossible; err_collision is tied 0.

Decomposition:
- Shared package reg_bus_pkg holds:
  - FSM state encoding (IDLE, WAIT, RESP, DRAIN);
  - default bus widths ADDR_W=4, DATA_W=4;
  - err_count width constant.
- One sub-module, ack_priority_select: a parametrised one-hot lowest-index encoder that outputs the winner index, ack_any and ack_multi.
- FSM, counter, data mux and statistics remain in reg_bus_interconnect.

Test Plan:
- Read, single slave: m_valid=1, address=4'h3; slave 2 asserts s_ack and s_data_out_valid with data 4'hA on WAIT cycle 2 → m_ack and m_data_out_valid at the next cycle, m_data_out=4'hA, no error pulses.
- Write: slave 0 asserts s_ack only on WAIT cycle 1 → m_ack pulse; m_data_out_valid=0; m_data_out unchanged from the prior value.
- Collision: slaves 1 and 3 ack in the same cycle with data 4'h5 and 4'hC → m_data_out=4'h5; err_collision pulse; err_count 0→1.
- Timeout with TIMEOUT=15 and no ack → m_ack and err_timeout 16 cycles after WAIT entry; m_data_out=0; err_count increments.
- Held request: m_valid kept high 10 cycles after m_ack → exactly one m_ack; s_valid stays 0 until m_valid falls and a new request arrives.
- Reset asserted during WAIT → all outputs 0 immediately; err_count=0; no m_ack after release. Also: 256 forced timeouts → err_count saturates at 255.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus interconnect: FSM encoding,
// default bus widths and the error-statistics helpers.
package reg_bus_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;
  localparam int ERR_CNT_W  = 8;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} bus_state_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ack_priority_select.sv
// Lowest-index-wins encoder over the slave ack vector, plus any/multi flags
// used for completion and collision detection.
module ack_priority_select #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     ack,
  output logic [IDX_W-1:0] idx,
  output logic             ack_any,
  output logic             ack_multi
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (ack[i]) idx = IDX_W'(i);
  end

  assign ack_any   = |ack;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign ack_multi = |(ack & (ack - N'(1)));

endmodule

// File: rtl/reg_bus_interconnect.sv
// Register-bus interconnect: broadcasts one decoder request to all slaves,
// returns a registered single-cycle response, and flags collisions/timeouts.
module reg_bus_interconnect
  import reg_bus_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TIMEOUT  = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_valid,
  input  logic [ADDR_W-1:0]            m_address,
  input  logic [DATA_W-1:0]            m_data,
  output logic                         m_ack,
  output logic [DATA_W-1:0]            m_data_out,
  output logic                         m_data_out_valid,
  output logic                         s_valid,
  output logic [ADDR_W-1:0]            s_address,
  output logic [DATA_W-1:0]            s_data,
  input  logic [N_SLAVES-1:0]          s_ack,
  input  logic [N_SLAVES*DATA_W-1:0]   s_data_out,
  input  logic [N_SLAVES-1:0]          s_data_out_valid,
  output logic                         err_timeout,
  output logic                         err_collision,
  output logic [ERR_CNT_W-1:0]         err_count
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  bus_state_t                       state;
  logic [CNT_W-1:0]                 cnt;
  logic [N_SLAVES-1:0][DATA_W-1:0]  slv_data;
  logic [IDX_W-1:0]                 win;
  logic                             ack_any, ack_multi, collide, timed_out;

  assign slv_data  = s_data_out;
  assign collide   = (N_SLAVES > 1) && ack_multi;
  assign timed_out = (cnt == CNT_W'(TIMEOUT));

  ack_priority_select #(.N(N_SLAVES), .IDX_W(IDX_W)) u_sel (
    .ack       (s_ack),
    .idx       (win),
    .ack_any   (ack_any),
    .ack_multi (ack_multi)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      s_valid          <= 1'b0;
      s_address        <= '0;
      s_data           <= '0;
      m_ack            <= 1'b0;
      m_data_out       <= '0;
      m_data_out_valid <= 1'b0;
      err_timeout      <= 1'b0;
      err_collision    <= 1'b0;
      err_count        <= '0;
    end else begin
      m_ack            <= 1'b0;
      m_data_out_valid <= 1'b0;
      err_timeout      <= 1'b0;
      err_collision    <= 1'b0;
      case (state)
        IDLE: if (m_valid) begin
          s_address <= m_address;
          s_data    <= m_data;
          s_valid   <= 1'b1;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // An ack on the final counted cycle still completes normally.
          if (ack_any) begin
            s_valid       <= 1'b0;
            cnt           <= '0;
            m_ack         <= 1'b1;
            err_collision <= collide;
            if (s_data_out_valid[win]) begin
              m_data_out       <= slv_data[win];
              m_data_out_valid <= 1'b1;
            end
            if (collide) err_count <= sat_inc(err_count);
            state <= RESP;
          end else if (timed_out) begin
            s_valid     <= 1'b0;
            cnt         <= '0;
            m_ack       <= 1'b1;
            err_timeout <= 1'b1;
            m_data_out  <= '0;
            err_count   <= sat_inc(err_count);
            state       <= RESP;
          end
        end
        RESP:  state <= DRAIN;
        // Hold off until the decoder drops its request so it is not re-issued.
        DRAIN: if (!m_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_interconnect.sv
// Directed bench for reg_bus_interconnect: a transaction-level model predicts
// every output each cycle; a few literal pins anchor the model itself.
module tb_reg_bus_interconnect;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic [3:0]  m_address, m_data;
  logic        m_ack, m_data_out_valid, s_valid;
  logic [3:0]  m_data_out, s_address, s_data;
  logic [3:0]  s_ack, s_data_out_valid;
  logic [15:0] s_data_out;
  logic        err_timeout, err_collision;
  logic [7:0]  err_count;

  reg_bus_interconnect #(.N_SLAVES(4), .ADDR_W(4), .DATA_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_address(m_address), .m_data(m_data),
    .m_ack(m_ack), .m_data_out(m_data_out), .m_data_out_valid(m_data_out_valid),
    .s_valid(s_valid), .s_address(s_address), .s_data(s_data), .s_ack(s_ack),
    .s_data_out(s_data_out), .s_data_out_valid(s_data_out_valid),
    .err_timeout(err_timeout), .err_collision(err_collision), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Model expectations for the current cycle.
  logic       e_ack = 0, e_dv = 0, e_to = 0, e_col = 0, e_sv = 0;
  logic [3:0] e_mdo = 0, e_addr = 0, e_data = 0;
  int         e_err = 0;

  int vectors = 0, miscompares = 0;
  int cyc = 0, acks = 0, last_ack = 0, start_cyc = 0;

  typedef struct {string name; int act; int exp;} pin_t;
  pin_t pins[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic pin(input string n, input int a, input int e);
    pins.push_back('{n, a, e});
  endtask

  always @(negedge clk) begin
    pin_t p;
    chk("m_ack", int'(m_ack), int'(e_ack));
    chk("m_data_out_valid", int'(m_data_out_valid), int'(e_dv));
    chk("err_timeout", int'(err_timeout), int'(e_to));
    chk("err_collision", int'(err_collision), int'(e_col));
    chk("s_valid", int'(s_valid), int'(e_sv));
    chk("m_data_out", int'(m_data_out), int'(e_mdo));
    chk("err_count", int'(err_count), e_err);
    chk("s_address", int'(s_address), int'(e_addr));
    chk("s_data", int'(s_data), int'(e_data));
    while (pins.size() > 0) begin
      p = pins.pop_front();
      chk(p.name, p.act, p.exp);
    end
    if (m_ack) begin
      acks++;
      last_ack = cyc;
    end
  end

  // One request: slaves in ack_mask answer on WAIT cycle ack_cyc (0 = nobody).
  // hold keeps m_valid high that many cycles past m_ack while slaves spam acks.
  task automatic do_txn(input logic [3:0] addr, input logic [3:0] data, input int ack_cyc,
                        input logic [3:0] ack_mask, input logic [3:0] dv_mask,
                        input logic [15:0] sdo, input int hold);
    int  r, win;
    bit  to, col;
    to  = (ack_cyc == 0) || (ack_cyc > TIMEOUT + 1) || (ack_mask == 0);
    r   = to ? TIMEOUT + 2 : ack_cyc + 1;
    col = !to && ($countones(ack_mask) > 1);
    win = 0;
    for (int i = 3; i >= 0; i--) if (ack_mask[i]) win = i;
    start_cyc = cyc;
    for (int t = 0; t <= r + hold + 1; t++) begin
      m_valid          = (t <= r + hold);
      m_address        = addr;
      m_data           = data;
      s_data_out       = sdo;
      s_ack            = (!to && t == ack_cyc) ? ack_mask : (t > r && hold > 0) ? 4'hF : 4'h0;
      s_data_out_valid = (!to && t == ack_cyc) ? dv_mask  : (t > r && hold > 0) ? 4'hF : 4'h0;
      e_sv  = (t >= 1) && (t < r);
      e_ack = (t == r);
      e_to  = (t == r) && to;
      e_col = (t == r) && col;
      e_dv  = (t == r) && !to && dv_mask[win];
      if (t == 1) begin
        e_addr = addr;
        e_data = data;
      end
      if (t == r) begin
        if (to) e_mdo = 4'h0;
        else if (dv_mask[win]) e_mdo = sdo[win*4 +: 4];
        if (to || col) e_err = (e_err >= 255) ? 255 : e_err + 1;
      end
      @(posedge clk); #1;
    end
    m_valid = 0; s_ack = 0; s_data_out_valid = 0;
  endtask

  initial begin
    int acks0;
    rst = 0; m_valid = 0; m_address = 0; m_data = 0;
    s_ack = 0; s_data_out = 0; s_data_out_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;

    do_txn(4'h1, 4'h2, 1, 4'b0001, 4'b0001, 16'h0007, 0);
    pin("best_latency", last_ack - start_cyc, 2);
    pin("best_data", int'(m_data_out), 32'h7);

    do_txn(4'h3, 4'h0, 2, 4'b0100, 4'b0100, 16'h0A00, 0);
    pin("read_latency", last_ack - start_cyc, 3);
    pin("read_data", int'(m_data_out), 32'hA);
    pin("read_err", int'(err_count), 0);

    do_txn(4'h5, 4'h8, 1, 4'b0001, 4'b0000, 16'h000F, 0);
    pin("write_keeps_data", int'(m_data_out), 32'hA);

    do_txn(4'h6, 4'h1, 1, 4'b1010, 4'b1010, 16'hC050, 0);
    pin("collision_data", int'(m_data_out), 32'h5);
    pin("collision_err", int'(err_count), 1);

    do_txn(4'h9, 4'h4, 0, 4'b0000, 4'b0000, 16'hFFFF, 0);
    pin("timeout_latency", last_ack - start_cyc, 17);
    pin("timeout_data", int'(m_data_out), 0);
    pin("timeout_err", int'(err_count), 2);

    do_txn(4'hE, 4'h3, 16, 4'b1000, 4'b1000, 16'h9000, 0);
    pin("late_ack_latency", last_ack - start_cyc, 17);
    pin("late_ack_data", int'(m_data_out), 32'h9);
    pin("late_ack_err", int'(err_count), 2);

    acks0 = acks;
    do_txn(4'h2, 4'hD, 3, 4'b0010, 4'b0010, 16'h0030, 10);
    pin("held_single_ack", acks - acks0, 1);
    pin("held_data", int'(m_data_out), 32'h3);

    // Reset in the middle of WAIT.
    m_valid = 1; m_address = 4'hB; m_data = 4'h6;
    @(posedge clk); #1;
    e_sv = 1; e_addr = 4'hB; e_data = 4'h6;
    @(posedge clk); #1;
    acks0 = acks;
    #2;
    e_sv = 0; e_addr = 0; e_data = 0; e_mdo = 0; e_err = 0;
    rst = 0;
    #1;
    pin("rst_s_valid", int'(s_valid), 0);
    pin("rst_err_count", int'(err_count), 0);
    pin("rst_data_out", int'(m_data_out), 0);
    m_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (5) @(posedge clk);
    #1;
    pin("rst_no_ack", acks - acks0, 0);

    for (int i = 0; i < 256; i++)
      do_txn(4'(i), 4'(~i), 0, 4'b0000, 4'b0000, 16'h1234, 0);
    pin("sat_err_count", int'(err_count), 255);

    @(posedge clk); #1;
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
